// File: rtl/refill_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : refill_pkg
//  Purpose  : Shared types and sizing helpers for the refill line assembler.
//             Holds the FSM state encoding and the beat-count derivations.
//  Revision : 1.0  initial release
// ============================================================================
package refill_pkg;

    typedef enum logic [1:0] {
        RF_IDLE  = 2'd0,
        RF_FILL  = 2'd1,
        RF_WRITE = 2'd2,
        RF_DONE  = 2'd3
    } rf_state_t;

    // Number of refill beats needed to cover one line.
    function automatic int calc_nbeat(input int nb_col, input int col_width,
                                      input int beat_width);
        return (nb_col * col_width) / beat_width;
    endfunction

    // Width of a beat position / beat counter.
    function automatic int calc_bw(input int nbeat);
        return $clog2(nbeat);
    endfunction

endpackage : refill_pkg
`default_nettype wire

// File: rtl/beat_slot_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : beat_slot_decoder
//  Purpose  : Wrap-adds the critical beat position and the beat counter
//             (modulo NBEAT) and returns a one-hot slot enable for the line
//             buffer.
//  Ports    : i_base    - critical beat position (first beat of the burst)
//             i_offset  - number of beats already accepted
//             o_slot_en - one-hot enable, bit k selects beat slot k
//  Revision : 1.0  initial release
// ============================================================================
module beat_slot_decoder #(
    parameter int NBEAT = 16,
    parameter int BW    = 4
) (
    input  logic [BW-1:0]    i_base,
    input  logic [BW-1:0]    i_offset,
    output logic [NBEAT-1:0] o_slot_en
);

    logic [BW-1:0] w_slot;

    // BW-bit addition wraps naturally because NBEAT is a power of two.
    assign w_slot    = i_base + i_offset;
    assign o_slot_en = NBEAT'(1) << w_slot;

endmodule : beat_slot_decoder
`default_nettype wire

// File: rtl/refill_line_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : refill_line_assembler
//  Purpose  : Collects a wrap burst of narrow refill beats (critical word
//             first) into a flop line buffer and commits it to the line BRAM
//             with a single full-line write, then pulses done.
//  Ports    : clka/rstn                 - clock, synchronous active-low reset
//             req_valid/req_ready       - refill request handshake
//             req_index/req_word        - BRAM entry and critical beat slot
//             rvalid/rready/rdata/rlast - refill beat stream
//             addra/dina/wea            - BRAM write port
//             done/done_err             - completion pulse and length error
//             crit_valid/crit_data      - critical word forward
//  Config   : REFILL_CRIT_FWD_EN - when defined, the first accepted beat of
//             each request is forwarded (registered) on crit_valid/crit_data.
//  Revision : 1.0  initial release
// ============================================================================
module refill_line_assembler
    import refill_pkg::*;
#(
    parameter int NB_COL     = 64,
    parameter int COL_WIDTH  = 8,
    parameter int RAM_DEPTH  = 64,
    parameter int BEAT_WIDTH = 32
) (
    input  logic                                    clka,
    input  logic                                    rstn,
    input  logic                                    req_valid,
    output logic                                    req_ready,
    input  logic [$clog2(RAM_DEPTH)-1:0]            req_index,
    input  logic [calc_bw(calc_nbeat(NB_COL, COL_WIDTH, BEAT_WIDTH))-1:0] req_word,
    input  logic                                    rvalid,
    output logic                                    rready,
    input  logic [BEAT_WIDTH-1:0]                   rdata,
    input  logic                                    rlast,
    output logic [$clog2(RAM_DEPTH)-1:0]            addra,
    output logic [NB_COL*COL_WIDTH-1:0]             dina,
    output logic [NB_COL-1:0]                       wea,
    output logic                                    done,
    output logic                                    done_err,
    output logic                                    crit_valid,
    output logic [BEAT_WIDTH-1:0]                   crit_data
);

    localparam int c_IW    = $clog2(RAM_DEPTH);
    localparam int c_NBEAT = calc_nbeat(NB_COL, COL_WIDTH, BEAT_WIDTH);
    localparam int c_BW    = calc_bw(c_NBEAT);
    localparam int c_LW    = NB_COL * COL_WIDTH;
    localparam logic [c_BW-1:0] c_LAST_CNT = c_BW'(c_NBEAT - 1);

    rf_state_t          r_state;
    logic [c_BW-1:0]    r_cnt;
    logic [c_BW-1:0]    r_word;
    logic [c_IW-1:0]    r_index;
    logic               r_err;
    logic [BEAT_WIDTH-1:0] r_line [c_NBEAT];

    logic               w_beat_fire;
    logic [c_NBEAT-1:0] w_slot_en;
    logic [c_LW-1:0]    w_line_flat;

    assign w_beat_fire = (r_state == RF_FILL) && rvalid;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clka) begin
        if (!rstn) begin
            r_state <= RF_IDLE;
            r_cnt   <= '0;
            r_word  <= '0;
            r_index <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                RF_IDLE: begin
                    if (req_valid) begin
                        r_index <= req_index;
                        r_word  <= req_word;
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                        r_state <= RF_FILL;
                    end
                end
                RF_FILL: begin
                    if (rvalid) begin
                        r_cnt <= r_cnt + c_BW'(1);
                        if (r_cnt == c_LAST_CNT) begin
                            if (rlast) begin
                                r_state <= RF_WRITE;
                            end else begin
                                // Burst overran the line: drop it, stop accepting.
                                r_err   <= 1'b1;
                                r_state <= RF_DONE;
                            end
                        end else if (rlast) begin
                            // Burst ended short of a full line.
                            r_err   <= 1'b1;
                            r_state <= RF_DONE;
                        end
                    end
                end
                RF_WRITE: r_state <= RF_DONE;
                RF_DONE:  r_state <= RF_IDLE;
                default:  r_state <= RF_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Line buffer: one flop slot per beat, written through the decoder
    // ------------------------------------------------------------------
    beat_slot_decoder #(
        .NBEAT (c_NBEAT),
        .BW    (c_BW)
    ) u_slot_dec (
        .i_base    (r_word),
        .i_offset  (r_cnt),
        .o_slot_en (w_slot_en)
    );

    generate
        for (genvar k = 0; k < c_NBEAT; k++) begin : g_slot
            always_ff @(posedge clka) begin
                if (!rstn) begin
                    r_line[k] <= '0;
                end else if (w_beat_fire && w_slot_en[k]) begin
                    r_line[k] <= rdata;
                end
            end
            assign w_line_flat[k*BEAT_WIDTH +: BEAT_WIDTH] = r_line[k];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state, forced quiet during reset
    // ------------------------------------------------------------------
    assign req_ready = rstn && (r_state == RF_IDLE);
    assign rready    = rstn && (r_state == RF_FILL);
    assign wea       = (rstn && (r_state == RF_WRITE)) ? '1 : '0;
    assign addra     = rstn ? r_index : '0;
    assign dina      = rstn ? w_line_flat : '0;
    assign done      = rstn && (r_state == RF_DONE);
    assign done_err  = done && r_err;

`ifdef REFILL_CRIT_FWD_EN
    logic                  r_crit_valid;
    logic [BEAT_WIDTH-1:0] r_crit_data;

    always_ff @(posedge clka) begin
        if (!rstn) begin
            r_crit_valid <= 1'b0;
            r_crit_data  <= '0;
        end else begin
            // Counter at zero marks the critical (first) beat of the request.
            r_crit_valid <= w_beat_fire && (r_cnt == '0);
            if (w_beat_fire && (r_cnt == '0)) begin
                r_crit_data <= rdata;
            end
        end
    end

    assign crit_valid = rstn && r_crit_valid;
    assign crit_data  = rstn ? r_crit_data : '0;
`else
    assign crit_valid = 1'b0;
    assign crit_data  = '0;
`endif

endmodule : refill_line_assembler
`default_nettype wire

// File: tb/tb_refill_line_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_refill_line_assembler
//  Purpose  : Directed self-checking bench for refill_line_assembler at
//             default parameters (16 beats of 32 bits per 512-bit line).
//  Revision : 1.0  initial release
// ============================================================================
module tb_refill_line_assembler;

    logic          clka = 1'b0;
    logic          rstn;
    logic          req_valid;
    logic          req_ready;
    logic [5:0]    req_index;
    logic [3:0]    req_word;
    logic          rvalid;
    logic          rready;
    logic [31:0]   rdata;
    logic          rlast;
    logic [5:0]    addra;
    logic [511:0]  dina;
    logic [63:0]   wea;
    logic          done;
    logic          done_err;
    logic          crit_valid;
    logic [31:0]   crit_data;

    int n_checks = 0;
    int n_pass   = 0;

    // Observed activity, sampled at the falling edge.
    int           wr_cnt   = 0;
    logic [5:0]   wr_addr  = '0;
    logic [511:0] wr_data  = '0;
    logic [63:0]  wr_wea   = '0;
    int           done_cnt = 0;
    logic         last_err = 1'b0;
    int           crit_cnt = 0;

    refill_line_assembler dut (
        .clka       (clka),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_index  (req_index),
        .req_word   (req_word),
        .rvalid     (rvalid),
        .rready     (rready),
        .rdata      (rdata),
        .rlast      (rlast),
        .addra      (addra),
        .dina       (dina),
        .wea        (wea),
        .done       (done),
        .done_err   (done_err),
        .crit_valid (crit_valid),
        .crit_data  (crit_data)
    );

    always #5 clka = ~clka;

    always @(negedge clka) begin
        if (wea != '0) begin
            wr_cnt  = wr_cnt + 1;
            wr_addr = addra;
            wr_data = dina;
            wr_wea  = wea;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            last_err = done_err;
        end
        if (crit_valid) crit_cnt = crit_cnt + 1;
    end

    // ---------------- stimulus helpers (no checking inside) ----------------
    task automatic cyc();
        @(posedge clka);
        #1;
    endtask

    task automatic do_request(input logic [5:0] idx, input logic [3:0] word,
                              output bit ok);
        bit rdy;
        ok        = 1'b0;
        req_valid = 1'b1;
        req_index = idx;
        req_word  = word;
        for (int i = 0; i < 20; i++) begin
            rdy = req_ready;
            cyc();
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] data, input logic last,
                             input int gap, output bit ok);
        bit rdy;
        ok = 1'b0;
        for (int g = 0; g < gap; g++) cyc();
        rvalid = 1'b1;
        rdata  = data;
        rlast  = last;
        for (int i = 0; i < 10; i++) begin
            rdy = rready;
            cyc();
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn = 1'b0;
        cyc();
        cyc();
        n_checks++;
        if ({req_ready, rready, done, done_err, crit_valid} !== 5'b0 ||
            wea !== '0 || addra !== '0 || dina !== '0 || crit_data !== '0)
            $display("FAIL reset_outputs: got rdy=%b rr=%b wea=%h addra=%h done=%b",
                     req_ready, rready, wea, addra, done);
        else n_pass++;
        rstn = 1'b1;
        cyc();
        n_checks++;
        if (req_ready !== 1'b1 || rready !== 1'b0)
            $display("FAIL reset_idle: got req_ready=%b rready=%b expected 1/0",
                     req_ready, rready);
        else n_pass++;
    endtask

    task automatic test_aligned();
        bit ok, all_ok;
        logic [511:0] exp;
        int wr0;
        wr0    = wr_cnt;
        all_ok = 1'b1;
        do_request(6'd5, 4'd0, ok);
        all_ok &= ok;
        n_checks++;
        if (rready !== 1'b1)
            $display("FAIL aligned_rready: got %b expected 1", rready);
        else n_pass++;
        for (int i = 0; i < 16; i++) begin
            send_beat(32'(i), (i == 15), 0, ok);
            all_ok &= ok;
            exp[i*32 +: 32] = 32'(i);
        end
        n_checks++;
        if (!all_ok) $display("FAIL aligned_handshake: got timeout expected all accepted");
        else n_pass++;
        // Cycle after the last beat is the write cycle.
        n_checks++;
        if (wea !== {64{1'b1}} || addra !== 6'd5)
            $display("FAIL aligned_write: got wea=%h addra=%0d expected all ones / 5", wea, addra);
        else n_pass++;
        n_checks++;
        if (dina !== exp)
            $display("FAIL aligned_data: got %h expected %h", dina, exp);
        else n_pass++;
        cyc();
        n_checks++;
        if (done !== 1'b1 || done_err !== 1'b0 || wea !== '0)
            $display("FAIL aligned_done: got done=%b err=%b wea=%h expected 1/0/0",
                     done, done_err, wea);
        else n_pass++;
        cyc();
        n_checks++;
        if (req_ready !== 1'b1 || done !== 1'b0 || wr_cnt != wr0 + 1)
            $display("FAIL aligned_return: got req_ready=%b done=%b writes=%0d expected 1/0/%0d",
                     req_ready, done, wr_cnt - wr0, 1);
        else n_pass++;
    endtask

    task automatic test_wrap();
        bit ok, all_ok;
        logic [511:0] exp;
        int d0;
        d0     = done_cnt;
        all_ok = 1'b1;
        do_request(6'd9, 4'd13, ok);
        all_ok &= ok;
        for (int i = 0; i < 16; i++) begin
            send_beat(32'hA0 + 32'(i), (i == 15), 0, ok);
            all_ok &= ok;
            exp[((13 + i) % 16)*32 +: 32] = 32'hA0 + 32'(i);
        end
        cyc();
        cyc();
        n_checks++;
        if (!all_ok || done_cnt != d0 + 1 || last_err !== 1'b0)
            $display("FAIL wrap_done: got ok=%b dones=%0d err=%b expected 1/1/0",
                     all_ok, done_cnt - d0, last_err);
        else n_pass++;
        n_checks++;
        if (wr_addr !== 6'd9 || wr_data !== exp)
            $display("FAIL wrap_line: got addr=%0d data=%h expected 9 / %h", wr_addr, wr_data, exp);
        else n_pass++;
        n_checks++;
        if (wr_data[0 +: 32] !== 32'hA3 || wr_data[12*32 +: 32] !== 32'hAF)
            $display("FAIL wrap_slots: got slot0=%h slot12=%h expected a3/af",
                     wr_data[0 +: 32], wr_data[12*32 +: 32]);
        else n_pass++;
    endtask

    task automatic test_early_last();
        bit ok, all_ok;
        logic [511:0] exp;
        int wr0;
        wr0    = wr_cnt;
        all_ok = 1'b1;
        do_request(6'd2, 4'd0, ok);
        for (int i = 0; i < 9; i++) begin
            send_beat(32'h55 + 32'(i), (i == 8), 0, ok);
            all_ok &= ok;
        end
        n_checks++;
        if (done !== 1'b1 || done_err !== 1'b1 || wea !== '0)
            $display("FAIL early_done: got done=%b err=%b wea=%h expected 1/1/0",
                     done, done_err, wea);
        else n_pass++;
        cyc();
        // Follow-up request must complete cleanly.
        do_request(6'd3, 4'd0, ok);
        for (int i = 0; i < 16; i++) begin
            send_beat(32'h100 + 32'(i), (i == 15), 0, ok);
            all_ok &= ok;
            exp[i*32 +: 32] = 32'h100 + 32'(i);
        end
        cyc();
        cyc();
        n_checks++;
        if (!all_ok || wr_cnt != wr0 + 1 || last_err !== 1'b0 || wr_addr !== 6'd3 || wr_data !== exp)
            $display("FAIL early_recover: got ok=%b writes=%0d err=%b addr=%0d expected 1/1/0/3",
                     all_ok, wr_cnt - wr0, last_err, wr_addr);
        else n_pass++;
    endtask

    task automatic test_no_last();
        bit ok, all_ok, any_ready;
        int wr0;
        wr0    = wr_cnt;
        all_ok = 1'b1;
        do_request(6'd7, 4'd4, ok);
        for (int i = 0; i < 16; i++) begin
            send_beat(32'h77 + 32'(i), 1'b0, 0, ok);
            all_ok &= ok;
        end
        n_checks++;
        if (!all_ok || done !== 1'b1 || done_err !== 1'b1)
            $display("FAIL nolast_done: got ok=%b done=%b err=%b expected 1/1/1",
                     all_ok, done, done_err);
        else n_pass++;
        // Offer a 17th beat: must not be accepted.
        rvalid    = 1'b1;
        any_ready = rready;
        cyc();
        any_ready |= rready;
        cyc();
        rvalid = 1'b0;
        n_checks++;
        if (any_ready !== 1'b0 || wr_cnt != wr0)
            $display("FAIL nolast_extra: got rready_seen=%b writes=%0d expected 0/0",
                     any_ready, wr_cnt - wr0);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok, all_ok, bad;
        logic [511:0] exp;
        int wr0, d0;
        wr0    = wr_cnt;
        d0     = done_cnt;
        all_ok = 1'b1;
        do_request(6'd11, 4'd0, ok);
        for (int i = 0; i < 7; i++) send_beat(32'hEE, 1'b0, 0, ok);
        rstn = 1'b0;
        cyc();
        bad = (wea != '0) || done || rready || req_ready;
        cyc();
        bad |= (wea != '0) || done || rready || req_ready;
        rstn = 1'b1;
        cyc();
        cyc();
        cyc();
        n_checks++;
        if (bad || wr_cnt != wr0 || done_cnt != d0)
            $display("FAIL midreset_quiet: got bad=%b writes=%0d dones=%0d expected 0/0/0",
                     bad, wr_cnt - wr0, done_cnt - d0);
        else n_pass++;
        do_request(6'd12, 4'd0, ok);
        all_ok &= ok;
        for (int i = 0; i < 16; i++) begin
            send_beat(32'h300 + 32'(i), (i == 15), 0, ok);
            all_ok &= ok;
            exp[i*32 +: 32] = 32'h300 + 32'(i);
        end
        cyc();
        cyc();
        n_checks++;
        if (!all_ok || wr_cnt != wr0 + 1 || wr_addr !== 6'd12 || wr_data !== exp || last_err !== 1'b0)
            $display("FAIL midreset_refill: got ok=%b writes=%0d addr=%0d data=%h expected 1/1/12/%h",
                     all_ok, wr_cnt - wr0, wr_addr, wr_data, exp);
        else n_pass++;
    endtask

    task automatic test_crit();
        bit ok, all_ok;
        int c0;
        c0     = crit_cnt;
        all_ok = 1'b1;
        do_request(6'd20, 4'd3, ok);
        send_beat(32'hDEADBEEF, 1'b0, 2, ok);
        all_ok &= ok;
`ifdef REFILL_CRIT_FWD_EN
        n_checks++;
        if (crit_valid !== 1'b1 || crit_data !== 32'hDEADBEEF)
            $display("FAIL crit_fwd: got valid=%b data=%h expected 1/deadbeef",
                     crit_valid, crit_data);
        else n_pass++;
        cyc();
        n_checks++;
        if (crit_valid !== 1'b0)
            $display("FAIL crit_pulse: got valid=%b expected 0", crit_valid);
        else n_pass++;
`endif
        for (int i = 1; i < 16; i++) begin
            send_beat(32'h40 + 32'(i), (i == 15), 2, ok);
            all_ok &= ok;
        end
        cyc();
        cyc();
        n_checks++;
        if (!all_ok || last_err !== 1'b0 || wr_data[3*32 +: 32] !== 32'hDEADBEEF ||
            wr_data[2*32 +: 32] !== 32'h4F)
            $display("FAIL crit_line: got ok=%b err=%b slot3=%h slot2=%h expected 1/0/deadbeef/4f",
                     all_ok, last_err, wr_data[3*32 +: 32], wr_data[2*32 +: 32]);
        else n_pass++;
`ifdef REFILL_CRIT_FWD_EN
        n_checks++;
        if (crit_cnt != c0 + 1)
            $display("FAIL crit_count: got %0d expected 1", crit_cnt - c0);
        else n_pass++;
`else
        n_checks++;
        if (crit_cnt != 0 || c0 != 0)
            $display("FAIL crit_off: got crit_valid cycles=%0d expected 0", crit_cnt);
        else n_pass++;
`endif
    endtask

    initial begin
        rstn      = 1'b0;
        req_valid = 1'b0;
        req_index = '0;
        req_word  = '0;
        rvalid    = 1'b0;
        rdata     = '0;
        rlast     = 1'b0;
        test_reset();
        test_aligned();
        test_wrap();
        test_early_last();
        test_no_last();
        test_reset_mid();
        test_crit();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_refill_line_assembler
`default_nettype wire
